// File: rtl/patgen_pkg.sv
// rtl/patgen_pkg.sv - shared state type, width limit and LFSR tap table for pattern_gen
package patgen_pkg;

    localparam int PATGEN_MAX_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Right-shift Galois toggle masks; bit k-1 set means polynomial term x^k.
    function automatic logic [PATGEN_MAX_WIDTH-1:0] lfsr_taps(input int width);
        case (width)
            2:       lfsr_taps = 16'h0003;
            3:       lfsr_taps = 16'h0006;
            4:       lfsr_taps = 16'h000C;
            5:       lfsr_taps = 16'h0014;
            6:       lfsr_taps = 16'h0030;
            7:       lfsr_taps = 16'h0060;
            8:       lfsr_taps = 16'h00B8;
            9:       lfsr_taps = 16'h0110;
            10:      lfsr_taps = 16'h0240;
            11:      lfsr_taps = 16'h0500;
            12:      lfsr_taps = 16'h0E08;
            13:      lfsr_taps = 16'h1C80;
            14:      lfsr_taps = 16'h3802;
            15:      lfsr_taps = 16'h6000;
            16:      lfsr_taps = 16'hD008;
            default: lfsr_taps = 16'h0000;
        endcase
    endfunction

endpackage

// File: rtl/patgen_lfsr.sv
// rtl/patgen_lfsr.sv - combinational Galois LFSR step and seed substitution for pattern_gen
module patgen_lfsr
    import patgen_pkg::*;
#(
    parameter int          WIDTH     = 2,
    parameter int unsigned LFSR_SEED = 1
) (
    input  logic [WIDTH-1:0] state_i,
    output logic [WIDTH-1:0] next_o,
    output logic [WIDTH-1:0] seed_o
);

    localparam logic [PATGEN_MAX_WIDTH-1:0] TAPS_FULL = lfsr_taps(WIDTH);
    localparam logic [WIDTH-1:0]            TAPS      = TAPS_FULL[WIDTH-1:0];
    localparam logic [WIDTH-1:0]            SEED_RAW  = WIDTH'(LFSR_SEED);

    // All-zeros is the lock-up state of the LFSR, so it can never be a start point.
    assign seed_o = (SEED_RAW == '0) ? WIDTH'(1) : SEED_RAW;
    assign next_o = (state_i >> 1) ^ (state_i[0] ? TAPS : '0);

endmodule

// File: rtl/pattern_gen.sv
// rtl/pattern_gen.sv - handshaked exhaustive/LFSR pattern source; LFSR mode built only with PATGEN_LFSR_EN
module pattern_gen
    import patgen_pkg::*;
#(
    parameter int          WIDTH     = 2,
    parameter int unsigned LFSR_SEED = 1,
    parameter int unsigned LFSR_N    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    output logic [WIDTH-1:0] pat_out,
    output logic             pat_valid,
    input  logic             pat_ready,
    output logic             pat_last,
    output logic [WIDTH:0]   pat_count,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [WIDTH:0]   cnt_q, cnt_d;

    logic [WIDTH-1:0] start_pat;
    logic [WIDTH-1:0] step_pat;
    logic             last_hit;

`ifdef PATGEN_LFSR_EN
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] lfsr_next;
    logic [WIDTH-1:0] lfsr_seed;

    patgen_lfsr #(
        .WIDTH     (WIDTH),
        .LFSR_SEED (LFSR_SEED)
    ) u_lfsr (
        .state_i (pat_q),
        .next_o  (lfsr_next),
        .seed_o  (lfsr_seed)
    );

    assign start_pat = mode ? lfsr_seed : '0;
    assign step_pat  = mode_q ? lfsr_next : pat_q + 1'b1;
    assign last_hit  = mode_q ? (cnt_q == (WIDTH+1)'(LFSR_N - 1)) : (pat_q == '1);
`else
    logic unused_cfg;

    assign unused_cfg = ^{mode, LFSR_SEED[0], LFSR_N[0]};
    assign start_pat  = '0;
    assign step_pat   = pat_q + 1'b1;
    assign last_hit   = (pat_q == '1);
`endif

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        cnt_d   = cnt_q;
`ifdef PATGEN_LFSR_EN
        mode_d  = mode_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    pat_d   = start_pat;
`ifdef PATGEN_LFSR_EN
                    mode_d  = mode;
`endif
                end
            end
            RUN: begin
                if (pat_ready) begin
                    cnt_d = cnt_q + 1'b1;
                    // The final pattern stays on pat_out through DONE and IDLE.
                    if (last_hit) state_d = DONE;
                    else          pat_d   = step_pat;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pat_q   <= '0;
            cnt_q   <= '0;
`ifdef PATGEN_LFSR_EN
            mode_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            cnt_q   <= cnt_d;
`ifdef PATGEN_LFSR_EN
            mode_q  <= mode_d;
`endif
        end
    end

    assign pat_out   = pat_q;
    assign pat_count = cnt_q;
    assign pat_valid = (state_q == RUN);
    assign busy      = (state_q == RUN);
    assign pat_last  = (state_q == RUN) && last_hit;
    assign done      = (state_q == DONE);

endmodule
